// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding and defaults for the stopwatch control unit.
package stopwatch_pkg;
  localparam int STATE_W = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 1000000;
  typedef enum logic [STATE_W-1:0] {
    ST_STOP  = 2'b00,
    ST_RUN   = 2'b01,
    ST_CLEAR = 2'b10
  } state_t;
endpackage

// File: rtl/stopwatch_cu_if.sv
// stopwatch_cu_if: button inputs and datapath controls of the stopwatch control unit.
interface stopwatch_cu_if;
  import stopwatch_pkg::*;
  logic i_btn_run_stop;
  logic i_btn_clear;
  logic i_btn_lap;
  logic o_run;
  logic o_clear;
  logic o_lap_hold;
  logic [STATE_W-1:0] o_state;
  modport master (output i_btn_run_stop, i_btn_clear, i_btn_lap, input o_run, o_clear, o_lap_hold, o_state);
  modport slave (input i_btn_run_stop, i_btn_clear, i_btn_lap, output o_run, o_clear, o_lap_hold, o_state);
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser, saturating debounce counter and registered rising-edge pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_pulse
);
  logic r_s1, r_s2, r_level, r_level_d, r_pulse;
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
      if (r_s2 == r_level) r_cnt <= '0;
      else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
        r_level <= r_s2;
        r_cnt   <= '0;
      end else r_cnt <= r_cnt + 1'b1;
      r_level_d <= r_level;
      r_pulse   <= r_level & ~r_level_d;
    end
  end
  assign o_level = r_level;
  assign o_pulse = r_pulse;
endmodule

// File: rtl/stopwatch_cu.sv
// stopwatch_cu: debounced buttons drive a STOP/RUN/CLEAR Moore FSM for the stopwatch datapath.
// Optional lap-hold channel enabled by STOPWATCH_LAP_EN.
module stopwatch_cu
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input logic           clk,
  input logic           rst,
  stopwatch_cu_if.slave bus
);
  logic w_lvl_rs, w_pls_rs, w_lvl_cl, w_pls_cl, w_rs, w_cl;
  state_t r_state, w_next;
  logic r_run, r_clear;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rs (
    .clk(clk), .rst(rst), .i_btn(bus.i_btn_run_stop), .o_level(w_lvl_rs), .o_pulse(w_pls_rs)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_cl (
    .clk(clk), .rst(rst), .i_btn(bus.i_btn_clear), .o_level(w_lvl_cl), .o_pulse(w_pls_cl)
  );
  assign w_rs = w_pls_rs & w_lvl_rs;
  assign w_cl = w_pls_cl & w_lvl_cl;
  // CLEAR and the unused encoding both fall back to STOP, dropping any pulses
  always_comb begin
    w_next = ST_STOP;
    case (r_state)
      ST_STOP: w_next = w_rs ? ST_RUN : (w_cl ? ST_CLEAR : ST_STOP);
      ST_RUN:  w_next = w_rs ? ST_STOP : ST_RUN;
      default: w_next = ST_STOP;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_STOP;
      r_run   <= 1'b0;
      r_clear <= 1'b0;
    end else begin
      r_state <= w_next;
      r_run   <= (w_next == ST_RUN);
      r_clear <= (w_next == ST_CLEAR);
    end
  end
`ifdef STOPWATCH_LAP_EN
  logic w_lvl_lp, w_pls_lp, r_lap;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lp (
    .clk(clk), .rst(rst), .i_btn(bus.i_btn_lap), .o_level(w_lvl_lp), .o_pulse(w_pls_lp)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_lap <= 1'b0;
    else r_lap <= (w_next == ST_CLEAR) ? 1'b0 :
                  (r_state == ST_RUN && w_pls_lp && w_lvl_lp) ? ~r_lap : r_lap;
  end
  assign bus.o_lap_hold = r_lap;
`else
  assign bus.o_lap_hold = 1'b0;
`endif
  assign bus.o_run   = r_run;
  assign bus.o_clear = r_clear;
  assign bus.o_state = r_state;
endmodule

// File: doc/stopwatch_cu.md
Name: stopwatch_cu

Overview:
Control unit for the stopwatch datapath. It turns raw push-button inputs into the datapath's `run` and `clear` controls.
- Raw buttons are synchronised and debounced, then edge-detected.
- A Moore FSM (STOP / RUN / CLEAR) sequences the datapath.
- The block sits between the board buttons and stopwatch_dp; its outputs drive stopwatch_dp.run and stopwatch_dp.clear directly.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles required before a debounced level changes (>=2).
CNT_W, $clog2(DEBOUNCE_CYCLES+1), width of each debounce counter.

Ports:
clk  input  1  system clock (100 MHz).
rst  input  1  asynchronous, active-low reset (0 = reset).
i_btn_run_stop  input  1  raw run/stop button, active-high, asynchronous to clk.
i_btn_clear  input  1  raw clear button, active-high, asynchronous.
i_btn_lap  input  1  raw lap button, active-high; used only with STOPWATCH_LAP_EN.
o_run  output  1  to datapath run; 1 only in RUN.
o_clear  output  1  to datapath clear; 1 only in CLEAR.
o_lap_hold  output  1  display freeze request; 0 without STOPWATCH_LAP_EN.
o_state  output  2  current FSM state: STOP=2'b00, RUN=2'b01, CLEAR=2'b10.

Behaviour:
- Reset (rst=0, async): FSM=STOP, o_run=0, o_clear=0, o_lap_hold=0, o_state=00. All synchronisers, debounce counters and debounced levels are 0.
- Per button:
  - 2-FF synchroniser.
  - Debounce counter increments while the synced value differs from the debounced level.
  - The counter clears to 0 whenever the synced value equals the level.
  - When the counter reaches DEBOUNCE_CYCLES, the level takes the synced value and the counter clears.
  - The counter saturates and never wraps.
- Edge pulse: 1-cycle pulse on a 0->1 transition of the debounced level, registered.
- Release transitions produce no pulse.
- Latency: raw high first sampled at cycle N gives a pulse at cycle N+DEBOUNCE_CYCLES+3. FSM outputs change at N+DEBOUNCE_CYCLES+4.
- Glitches shorter than DEBOUNCE_CYCLES synced cycles produce no pulse.
- FSM (registered Moore outputs):
  - STOP: run_stop pulse -> RUN. Else clear pulse -> CLEAR. Else stay.
  - RUN: run_stop pulse -> STOP. Clear pulse is ignored (no clear while running).
  - CLEAR: unconditionally -> STOP after exactly one cycle. All pulses arriving in that cycle are dropped.
  - Illegal encoding 2'b11 -> STOP on the next clk.
- Simultaneous run_stop and clear pulses in STOP: run_stop wins, go to RUN.
- o_run = (state==RUN). o_clear = (state==CLEAR); always exactly one cycle wide.
- Holding a button yields exactly one pulse, regardless of hold length.
- Reset asserted mid-debounce or mid-CLEAR: everything returns to reset values immediately. A button held through reset release produces a pulse once it is debounced.

Optional Feature:
Macro: STOPWATCH_LAP_EN.
- Defined:
  - A third debounce/edge channel on i_btn_lap.
  - In RUN, a lap pulse toggles o_lap_hold. The datapath keeps counting; the display mux shows its latched copy while o_lap_hold=1.
  - In STOP, lap pulses are ignored and the hold value is retained.
  - Entering CLEAR forces o_lap_hold=0.
  - Lap coincident with run_stop in RUN: both take effect.
- Not defined: no lap channel logic; i_btn_lap is ignored; o_lap_hold is tied to 0.

Decomposition:
- Package stopwatch_pkg:
  - state localparams ST_STOP/ST_RUN/ST_CLEAR;
  - STATE_W=2;
  - default DEBOUNCE_CYCLES.
- Sub-module btn_debounce: parameter DEBOUNCE_CYCLES; ports clk, rst, i_btn, o_level, o_pulse. It is instantiated 2x, or 3x with the lap feature.
- The FSM stays in stopwatch_cu.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset -> o_state=00, o_run=0, o_clear=0, o_lap_hold=0. Assert rst=0 asynchronously mid-RUN -> o_run=0 without waiting for a clk edge.
- run_stop held 20 cycles from cycle 10 -> single pulse at cycle 17, o_run=1 from cycle 18. A second press later -> o_run=0 (STOP).
- run_stop glitch high for 3 cycles -> no pulse, o_state stays 00.
- In STOP, press clear -> o_clear=1 for exactly 1 cycle, then o_state=00. In RUN, press clear -> no change, o_run stays 1.
- In STOP, press run_stop and clear on the same cycle -> o_state=01, o_clear never asserted.
- With STOPWATCH_LAP_EN: RUN + lap press -> o_lap_hold=1; second lap -> 0; lap then clear (via STOP) -> o_lap_hold=0.
